// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and default width for the multi-cycle
// execute-stage ALU / multiply-divide unit.
package alu_pkg;

    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_SLT  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOR  = 4'h7;
    localparam logic [3:0] OP_MULU = 4'h8;
    localparam logic [3:0] OP_DIV  = 4'h9;
    localparam logic [3:0] OP_DIVU = 4'hA;
    localparam logic [3:0] OP_SLTU = 4'hB;
    localparam logic [3:0] OP_MFHI = 4'hC;
    localparam logic [3:0] OP_MFLO = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIVI = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign fix-up folded into the last step.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  isDiv,
    input  logic                  isSigned,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hiOut,
    output logic [DATA_WIDTH-1:0] loOut
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_isDiv;
    logic           r_negLo;
    logic           r_negHi;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic [W-1:0]   r_opnd;

    logic [W-1:0]   w_magA;
    logic [W-1:0]   w_magB;
    logic [W:0]     w_mulSum;
    logic [W:0]     w_divShift;
    logic [W:0]     w_divDiff;
    logic           w_qBit;
    logic [W-1:0]   w_nextHi;
    logic [W-1:0]   w_nextLo;
    logic [2*W-1:0] w_prod;

    always_comb begin
        w_magA = (isSigned && A[W-1]) ? -A : A;
        w_magB = (isSigned && B[W-1]) ? -B : B;
    end

    // Multiply keeps the multiplier in r_lo and shifts the product in from the top;
    // divide shifts the dividend out of r_lo while quotient bits fill in behind it.
    always_comb begin
        w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_divShift = {r_hi, r_lo[W-1]};
        w_divDiff  = w_divShift - {1'b0, r_opnd};
        w_qBit     = ~w_divDiff[W];
        if (r_isDiv) begin
            w_nextHi = w_qBit ? w_divDiff[W-1:0] : w_divShift[W-1:0];
            w_nextLo = {r_lo[W-2:0], w_qBit};
        end else begin
            w_nextHi = w_mulSum[W:1];
            w_nextLo = {w_mulSum[0], r_lo[W-1:1]};
        end
        w_prod = {w_nextHi, w_nextLo};
        if (r_isDiv) begin
            loOut = r_negLo ? -w_nextLo : w_nextLo;
            hiOut = r_negHi ? -w_nextHi : w_nextHi;
        end else begin
            {hiOut, loOut} = r_negLo ? -w_prod : w_prod;
        end
        done = r_busy && (r_cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_isDiv <= 1'b0;
            r_negLo <= 1'b0;
            r_negHi <= 1'b0;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_cnt   <= CW'(W - 1);
            r_isDiv <= isDiv;
            r_negLo <= isSigned && (A[W-1] ^ B[W-1]);
            r_negHi <= isSigned && (isDiv ? A[W-1] : (A[W-1] ^ B[W-1]));
        end else if (r_busy) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            r_hi   <= '0;
            r_lo   <= isDiv ? w_magA : w_magB;
            r_opnd <= isDiv ? w_magB : w_magA;
        end else if (r_busy) begin
            r_hi <= w_nextHi;
            r_lo <= w_nextLo;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with valid/ready handshake on both sides; single-cycle ops finish
// immediately, multiply/divide run through alu_iter_core and update HI/LO.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [OP_WIDTH-1:0]   aluFunc,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] aluOut,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  divByZero
);

    localparam int W = DATA_WIDTH;

    state_t       r_state;
    state_t       w_nextState;
    logic [3:0]   w_op;
    logic         w_isMul;
    logic         w_isDiv;
    logic         w_divZero;
    logic         w_accept;
    logic         w_start;
    logic         w_coreDone;
    logic [W-1:0] w_coreHi;
    logic [W-1:0] w_coreLo;
    logic         r_outValid;
    logic [W-1:0] r_aluOut;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;
    logic         r_divByZero;

    function automatic logic [W-1:0] f_single(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [W-1:0] h,
                                              input logic [W-1:0] l);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: return {{(W-1){1'b0}}, (a < b)};
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_MFHI: return h;
            OP_MFLO: return l;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        w_op      = aluFunc[3:0];
        w_isMul   = (w_op == OP_MUL) || (w_op == OP_MULU);
        w_isDiv   = (w_op == OP_DIV) || (w_op == OP_DIVU);
        w_divZero = w_isDiv && (B == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A result taken in DONE frees the slot in the same cycle, so DONE falls
    // through to the IDLE dispatch rules.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (r_state == ST_DONE && !outReady) begin
                    w_nextState = ST_DONE;
                end else if (w_accept) begin
                    if (w_isMul)                     w_nextState = ST_MULT;
                    else if (w_isDiv && !w_divZero)  w_nextState = ST_DIVI;
                    else                             w_nextState = ST_DONE;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_MULT, ST_DIVI: begin
                if (w_coreDone) w_nextState = ST_DONE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        inReady  = (r_state == ST_IDLE) || (r_state == ST_DONE && outReady);
        w_accept = inValid && inReady;
        w_start  = w_accept && (w_isMul || (w_isDiv && !w_divZero));
    end

    alu_iter_core #(.DATA_WIDTH(W)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_start),
        .isDiv    (w_isDiv),
        .isSigned ((w_op == OP_MUL) || (w_op == OP_DIV)),
        .A        (A),
        .B        (B),
        .done     (w_coreDone),
        .hiOut    (w_coreHi),
        .loOut    (w_coreLo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid  <= 1'b0;
            r_aluOut    <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_divByZero <= 1'b0;
        end else begin
            r_outValid <= (w_nextState == ST_DONE);
            if (w_coreDone) begin
                r_hi        <= w_coreHi;
                r_lo        <= w_coreLo;
                r_aluOut    <= w_coreLo;
                r_divByZero <= 1'b0;
            end else if (w_accept && !w_start) begin
                if (w_divZero) begin
                    r_hi        <= A;
                    r_lo        <= '1;
                    r_aluOut    <= '1;
                    r_divByZero <= 1'b1;
                end else begin
                    r_aluOut    <= f_single(w_op, A, B, r_hi, r_lo);
                    r_divByZero <= 1'b0;
                end
            end
        end
    end

    assign outValid  = r_outValid;
    assign aluOut    = r_aluOut;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign divByZero = r_divByZero;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed cases, randomized ops against a
// plain-arithmetic model, back-to-back throughput, back-pressure and reset.
module tb_alu_mdu;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [3:0]  aluFunc;
    logic [31:0] A;
    logic [31:0] B;
    logic        outValid;
    logic        outReady;
    logic [31:0] aluOut;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divByZero;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_mdu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inValid   (inValid),
        .inReady   (inReady),
        .aluFunc   (aluFunc),
        .A         (A),
        .B         (B),
        .outValid  (outValid),
        .outReady  (outReady),
        .aluOut    (aluOut),
        .hi        (hi),
        .lo        (lo),
        .divByZero (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: results straight from the arithmetic definitions.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic dbz);
        longint      sa;
        longint      sb;
        longint      sp;
        logic [63:0] up;
        sa  = $signed(a);
        sb  = $signed(b);
        dbz = 1'b0;
        res = '0;
        case (op)
            4'h0: res = a + b;
            4'h1: res = a - b;
            4'h2: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; res = m_lo; end
            4'h3: res = (sa < sb) ? 32'd1 : 32'd0;
            4'h4: res = a & b;
            4'h5: res = a | b;
            4'h6: res = a ^ b;
            4'h7: res = ~(a | b);
            4'h8: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; res = m_lo; end
            4'h9, 4'hA: begin
                if (b == 0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF; dbz = 1'b1;
                end else if (op == 4'h9) begin
                    sp = sa / sb; m_lo = sp[31:0];
                    sp = sa % sb; m_hi = sp[31:0];
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
                res = m_lo;
            end
            4'hB: res = (a < b) ? 32'd1 : 32'd0;
            4'hC: res = m_hi;
            4'hD: res = m_lo;
            default: res = '0;
        endcase
    endfunction

    // Presents one request, waits for acceptance and then for outValid.
    // lat counts edges from the accepting edge (1 = visible right after it);
    // busyRdy counts cycles with inReady high while the result was pending.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rdy, output int lat, output int busyRdy);
        int guard;
        lat     = -1;
        busyRdy = 0;
        guard   = 0;
        @(negedge clk);
        inValid  = 1'b1;
        aluFunc  = op;
        A        = a;
        B        = b;
        outReady = rdy;
        #1;
        while (!inReady && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
        aluFunc = 4'($urandom);
        A       = $urandom;
        B       = $urandom;
        for (int c = 1; c <= 100; c++) begin
            if (outValid) begin
                lat = c;
                break;
            end
            if (inReady) busyRdy++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b1;
        aluFunc  = '0;
        A        = '0;
        B        = '0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({outValid, aluOut, hi, lo, divByZero} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b out=%h hi=%h lo=%h dbz=%b, required all 0",
                     outValid, aluOut, hi, lo, divByZero);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got inReady=%b outValid=%b, required 1/0", inReady, outValid);
        end
    endtask

    task automatic test_single_cycle();
        int lat, br;
        logic [31:0] r;
        logic d;
        logic [3:0]  ops[4]  = '{4'h0, 4'h3, 4'hB, 4'h7};
        logic [31:0] as[4]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h0F0F_0000};
        logic [31:0] bs[4]   = '{32'h1, 32'h3, 32'h3, 32'h00F0_000F};
        logic [31:0] exps[4] = '{32'h0, 32'h1, 32'h0, 32'hF000_FFF0};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 1'b1, lat, br);
            model(ops[i], as[i], bs[i], r, d);
            n_tests++;
            if (aluOut !== exps[i] || lat != 1) begin
                n_fail++;
                $display("FAIL single_op%0h: got out=%h lat=%0d, required out=%h lat=1",
                         ops[i], aluOut, lat, exps[i]);
            end
            n_tests++;
            if (hi !== m_hi || lo !== m_lo || divByZero !== 1'b0) begin
                n_fail++;
                $display("FAIL single_hilo%0h: got hi=%h lo=%h dbz=%b, required hi=%h lo=%h dbz=0",
                         ops[i], hi, lo, divByZero, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_muldiv();
        int lat, br;
        logic [31:0] r;
        logic d;
        logic [3:0]  ops[4] = '{4'h2, 4'h8, 4'h9, 4'h9};
        logic [31:0] as[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] bs[4]  = '{32'h2, 32'h2, 32'h2, 32'hFFFF_FFFF};
        logic [31:0] ehi[4] = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] elo[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h8000_0000};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 1'b1, lat, br);
            model(ops[i], as[i], bs[i], r, d);
            n_tests++;
            if (hi !== ehi[i] || lo !== elo[i] || aluOut !== elo[i]) begin
                n_fail++;
                $display("FAIL muldiv%0d_result: got hi=%h lo=%h out=%h, required hi=%h lo=%h",
                         i, hi, lo, aluOut, ehi[i], elo[i]);
            end
            n_tests++;
            if (lat != 33 || br != 0) begin
                n_fail++;
                $display("FAIL muldiv%0d_timing: got lat=%0d readyWhileBusy=%0d, required 33/0", i, lat, br);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat, br;
        logic [31:0] r;
        logic d;
        issue(4'hA, 32'd10, 32'd0, 1'b1, lat, br);
        model(4'hA, 32'd10, 32'd0, r, d);
        n_tests++;
        if (divByZero !== 1'b1 || lo !== 32'hFFFF_FFFF || hi !== 32'd10 || aluOut !== 32'hFFFF_FFFF || lat != 1) begin
            n_fail++;
            $display("FAIL divzero: got dbz=%b lo=%h hi=%h out=%h lat=%0d, required 1/ffffffff/0000000a/ffffffff/1",
                     divByZero, lo, hi, aluOut, lat);
        end
        issue(4'hC, 32'd0, 32'd0, 1'b1, lat, br);
        model(4'hC, 32'd0, 32'd0, r, d);
        n_tests++;
        if (aluOut !== 32'd10 || divByZero !== 1'b0) begin
            n_fail++;
            $display("FAIL mfhi_after_divzero: got out=%h dbz=%b, required 0000000a/0", aluOut, divByZero);
        end
    endtask

    task automatic test_random();
        int lat, br, elat;
        logic [3:0]  op;
        logic [31:0] a, b, r;
        logic d;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 7) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            elat = ((op == 4'h2) || (op == 4'h8) || ((op == 4'h9 || op == 4'hA) && b != 0)) ? 33 : 1;
            issue(op, a, b, 1'b1, lat, br);
            model(op, a, b, r, d);
            n_tests++;
            if (aluOut !== r || divByZero !== d || lat != elat) begin
                n_fail++;
                $display("FAIL rand%0d_op%0h: a=%h b=%h got out=%h dbz=%b lat=%0d, required out=%h dbz=%b lat=%0d",
                         i, op, a, b, aluOut, divByZero, lat, r, d, elat);
            end
            n_tests++;
            if (hi !== m_hi || lo !== m_lo) begin
                n_fail++;
                $display("FAIL rand%0d_hilo: got hi=%h lo=%h, required hi=%h lo=%h", i, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  singles[12] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        logic [3:0]  op;
        logic [31:0] a, b, r;
        logic d;
        @(negedge clk);
        outReady = 1'b1;
        inValid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            op = singles[$urandom_range(0, 11)];
            a  = $urandom;
            b  = $urandom;
            aluFunc = op;
            A = a;
            B = b;
            model(op, a, b, r, d);
            #1;
            n_tests++;
            if (inReady !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b%0d_ready: got inReady=%b, required 1", i, inReady);
            end
            @(posedge clk);
            #1;
            n_tests++;
            if (outValid !== 1'b1 || aluOut !== r) begin
                n_fail++;
                $display("FAIL b2b%0d_op%0h: got v=%b out=%h, required v=1 out=%h", i, op, outValid, aluOut, r);
            end
            @(negedge clk);
        end
        inValid = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat, br;
        logic [31:0] r;
        logic d;
        issue(4'h6, 32'h1234_5678, 32'h0F0F_F0F0, 1'b0, lat, br);
        model(4'h6, 32'h1234_5678, 32'h0F0F_F0F0, r, d);
        n_tests++;
        if (aluOut !== r || lat != 1) begin
            n_fail++;
            $display("FAIL bp_first: got out=%h lat=%0d, required out=%h lat=1", aluOut, lat, r);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (outValid !== 1'b1 || aluOut !== r || inReady !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b out=%h inReady=%b hi=%h lo=%h, required v=1 out=%h inReady=0 hi=%h lo=%h",
                         i, outValid, aluOut, inReady, hi, lo, r, m_hi, m_lo);
            end
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (outValid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got outValid=%b, required 0", outValid);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, br, seen;
        logic [31:0] r;
        logic d;
        issue(4'h8, 32'h1234_5678, 32'h0000_0100, 1'b1, lat, br);
        model(4'h8, 32'h1234_5678, 32'h0000_0100, r, d);
        n_tests++;
        if (hi !== 32'h12 || lo !== 32'h3456_7800) begin
            n_fail++;
            $display("FAIL pre_reset_mulu: got hi=%h lo=%h, required 00000012/34567800", hi, lo);
        end
        @(negedge clk);
        inValid  = 1'b1;
        aluFunc  = 4'h2;
        A        = 32'h7654_3210;
        B        = 32'h0000_0003;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_tests++;
        if (outValid !== 1'b0 || inReady !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_mul_busy: got outValid=%b inReady=%b, required 0/0", outValid, inReady);
        end
        #2 rst_n = 1'b0;
        m_hi = '0;
        m_lo = '0;
        #1;
        n_tests++;
        if ({outValid, aluOut, hi, lo, divByZero} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got v=%b out=%h hi=%h lo=%h dbz=%b, required all 0",
                     outValid, aluOut, hi, lo, divByZero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (outValid) seen++;
        end
        n_tests++;
        if (seen != 0 || inReady !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_abort: got outValid cycles=%0d inReady=%b, required 0/1", seen, inReady);
        end
        issue(4'hD, 32'd0, 32'd0, 1'b1, lat, br);
        model(4'hD, 32'd0, 32'd0, r, d);
        n_tests++;
        if (aluOut !== 32'd0 || lat != 1) begin
            n_fail++;
            $display("FAIL mid_reset_mflo: got out=%h lat=%0d, required 00000000/1", aluOut, lat);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_div_by_zero();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
